parity_frame_tx: RTL

- Downstream serializer for the parity stage: accepts a DATA_W-bit word over a valid/ready handshake and computes its parity bit.
- Shifts out an asynchronous-style frame on one line: start bit, data LSB-first, parity bit, stop bit.
- Bit timing comes from an internal baud counter. Feeds the board-level serial link.

---
 rtl/parity_pkg.sv | 31 +++
 rtl/parity_calc.sv | 15 +
 rtl/parity_frame_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame transmitter.
// Optional feature: define PARITY_TX_TWO_STOP_EN to send two stop bits per
// frame instead of one.
package parity_pkg;

   // Default data word width in bits.
   localparam int DATA_W_DEFAULT = 8;

   // Number of stop bits per frame.
`ifdef PARITY_TX_TWO_STOP_EN
   localparam int STOP_BITS = 2;
`else
   localparam int STOP_BITS = 1;
`endif

   // Frame sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   // Cycles from the first start-bit cycle to the last stop-bit cycle:
   // start bit, data bits, parity bit and stop bit(s), each clks_per_bit long.
   function automatic int frame_cycles(input int data_w, input int clks_per_bit);
      return (data_w + 2 + STOP_BITS) * clks_per_bit;
   endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: XOR reduction of the data word with an
// odd/even select. Even parity makes the total count of ones (data plus
// parity bit) even; odd parity makes it odd.
module parity_calc #(
   parameter int W = 8
) (
   input  logic [W-1:0] data_i,
   input  logic         odd_i,
   output logic         par_o
);

   // Even parity is the plain XOR reduction; odd parity is its complement.
   assign par_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter for the parity stage. Accepts a word over a
// valid/ready handshake and shifts out: start bit (0), data LSB-first,
// parity bit, stop bit(s) (1). Each bit lasts CLKS_PER_BIT clocks.
// Optional feature: define PARITY_TX_TWO_STOP_EN for two stop bits.
module parity_frame_tx
   import parity_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEFAULT,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_odd,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   // Index of the final stop bit (0 with one stop bit, 1 with two).
   localparam logic              STOP_LAST = (STOP_BITS > 1) ? 1'b1 : 1'b0;

   state_e              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                stop_q, stop_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_q, par_d;
   logic                tx_q, tx_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                par_w;
   logic                bit_end;

   parity_calc #(
      .W (DATA_W)
   ) u_parity_calc (
      .data_i (in_data),
      .odd_i  (in_odd),
      .par_o  (par_w)
   );

   // Bit-period boundary: last cycle of the current serial bit.
   assign bit_end = (baud_q == BAUD_LAST);

   // Next-state logic for the sequencer, counters and shift register.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis would infer a latch.
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;

      // The baud counter runs in every non-idle state and wraps at the end
      // of each bit; every state change happens on that wrap, so the
      // counter is always 0 on entry to a new state.
      if (state_q != ST_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_START;
               shift_d = in_data;
               par_d   = par_w;
               baud_d  = '0;
               bit_d   = '0;
               stop_d  = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_q == BIT_LAST) begin
                  state_d = ST_PARITY;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (stop_q == STOP_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output values for the next cycle, derived from the next state so that
   // every output comes straight from a flop.
   always_comb begin
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_STOP) && (baud_d == BAUD_LAST) && (stop_d == STOP_LAST);
   end

   // Control registers: sequencer, counters and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from values sampled at the same edge.
      if (rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Datapath registers: captured word and its parity bit.
   always_ff @(posedge clk) begin
      // NOTE: no reset here on purpose; both are loaded on every accept
      // before they can reach tx_out, and the IDLE line value ignores them.
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   assign tx_out     = tx_q;
   assign in_ready   = ready_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
